mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single Data_Memory port (enable/write/ack handshake, 256-bit lines) between two line-granular requesters: port 0 (dcache) and port 1 (instruction fetch / second cache).
Sits between the requesters' mem_* buses and Data_Memory. Grants one whole transaction at a time using round-robin priority, and keeps grant counters and a watchdog flag.

Parameters:
ADDR_W, 32, address width of every port
DATA_W, 256, line width of every port
CNT_W, 16, width of the saturating grant counters
TIMEOUT, 64, BUSY cycles without ack before timeout_o sets

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
p0_enable_i  in  1  port 0 request; held until p0_ack_o
p0_write_i  in  1  port 0: 1=write line, 0=read line
p0_addr_i  in  ADDR_W  port 0 byte address
p0_data_i  in  DATA_W  port 0 write data
p0_ack_o  out  1  port 0 transaction done (1-cycle pulse)
p0_data_o  out  DATA_W  port 0 read data, valid with p0_ack_o
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  same as port 0, for port 1
mem_enable_o  out  1  to Data_Memory enable_i
mem_write_o  out  1  to Data_Memory write_i
mem_addr_o  out  ADDR_W  to Data_Memory addr_i
mem_data_o  out  DATA_W  to Data_Memory data_i
mem_ack_i  in  1  from Data_Memory ack_o
mem_data_i  in  DATA_W  from Data_Memory data_o
gnt_cnt0_o  out  CNT_W  grants issued to port 0 (saturating)
gnt_cnt1_o  out  CNT_W  grants issued to port 1 (saturating)
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i=0, takes effect immediately): state=IDLE; owner=0; last_gnt=1; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0; both acks 0; counters 0; timeout_o=0; wait counter 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Only port 0 enabled -> grant 0. Only port 1 enabled -> grant 1.
  - Both enabled -> grant the port != last_gnt.
  - On grant: register owner's write/addr/data into mem_*_o, set mem_enable_o=1, set owner and last_gnt, increment that port's grant counter (saturates at all-ones), go to BUSY.
  - Latency: request sampled at edge N drives mem_enable_o from edge N onward (registered).
- BUSY:
  - mem_* outputs held constant.
  - Wait counter increments each cycle; when it reaches TIMEOUT, timeout_o sets and stays set until reset. The arbiter keeps waiting; it does not abort.
  - When mem_ack_i=1: owner's pX_ack_o=1 combinationally in the same cycle. Next edge: mem_enable_o=0, mem_write_o=0, wait counter clears, state goes to DONE.
- DONE: exactly one turnaround cycle with all requests ignored, so the finishing requester can drop its enable. Then return to IDLE.
- pX_ack_o = mem_ack_i & (state==BUSY) & (owner==X). The non-owner never sees an ack.
- p0_data_o = p1_data_o = mem_data_i (broadcast); only meaningful with the matching ack.
- mem_ack_i in IDLE or DONE (stale ack after reset) is ignored: no port ack, no state change.
- A request from the non-owner during BUSY or DONE waits; it is not dropped.
- Back-to-back: continuous requests from both ports alternate 0,1,0,1...
- A single port requesting alone is granted every IDLE visit; its minimum turnaround is ack + 2 cycles.
- Reset asserted mid-BUSY returns to IDLE immediately; the in-flight transaction is abandoned and no ack is issued.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - port id constants PORT_D=1'b0, PORT_I=1'b1;
  - the default ADDR_W/DATA_W values also used by Data_Memory and the caches.
- Single module; the arbitration is a few lines, so no sub-module.

Test Plan:
- Reset, then only p0 reads addr 0x00000000 (memory model acks 10 cycles after enable) -> mem_enable_o rises next edge with mem_addr_o=0; p0_ack_o pulses once with p0_data_o=0000_1111_…_FFFF; gnt_cnt0_o=1.
- p0 and p1 request in the same cycle (p0 write 0x200, p1 read 0x020) -> port 0 is served first, then port 1 after the DONE cycle; memory line 16 holds p0 data; p1_data_o=8888_9999_…_0000; each gnt_cnt=1.
- Both ports hold enable continuously for 6 transactions -> grant order 0,1,0,1,0,1; no ack ever goes to a non-owner.
- Assert rst_i=0 during BUSY, release, then the model's late ack arrives -> no pX_ack_o, state stays IDLE, mem_enable_o=0.
- Memory model never acks -> timeout_o=1 after 64 BUSY cycles and mem_enable_o stays 1; a later ack still completes the transaction, and timeout_o stays 1.
- Force gnt_cnt0 to 16'hFFFF, issue one more p0 grant -> gnt_cnt0_o stays 16'hFFFF.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared encodings and line geometry for the memory-side blocks
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 256;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin, whole-transaction arbiter for the shared Data_Memory port
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,

  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,

  output logic [CNT_W-1:0]  gnt_cnt0_o,
  output logic [CNT_W-1:0]  gnt_cnt1_o,
  output logic              timeout_o
);

  localparam int               WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  arb_state_e        state;
  logic              owner;
  logic              last_gnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic              grant_valid;
  logic              grant_port;

  // With both ports asking, the port that did not win last time goes first.
  always_comb begin
    grant_valid = p0_enable_i | p1_enable_i;
    if (p0_enable_i & p1_enable_i) begin
      grant_port = ~last_gnt;
    end else begin
      grant_port = p1_enable_i ? PORT_I : PORT_D;
    end
  end

  assign p0_ack_o  = mem_ack_i & (state == BUSY) & (owner == PORT_D);
  assign p1_ack_o  = mem_ack_i & (state == BUSY) & (owner == PORT_I);
  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      owner        <= PORT_D;
      last_gnt     <= PORT_I;
      wait_cnt     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      gnt_cnt0_o   <= '0;
      gnt_cnt1_o   <= '0;
      timeout_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state        <= BUSY;
            owner        <= grant_port;
            last_gnt     <= grant_port;
            wait_cnt     <= '0;
            mem_enable_o <= 1'b1;
            if (grant_port == PORT_I) begin
              mem_write_o <= p1_write_i;
              mem_addr_o  <= p1_addr_i;
              mem_data_o  <= p1_data_i;
              if (gnt_cnt1_o != CNT_MAX) begin
                gnt_cnt1_o <= gnt_cnt1_o + CNT_W'(1);
              end
            end else begin
              mem_write_o <= p0_write_i;
              mem_addr_o  <= p0_addr_i;
              mem_data_o  <= p0_data_i;
              if (gnt_cnt0_o != CNT_MAX) begin
                gnt_cnt0_o <= gnt_cnt0_o + CNT_W'(1);
              end
            end
          end
        end

        BUSY: begin
          if (mem_ack_i) begin
            state        <= DONE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            wait_cnt     <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            // The watchdog only flags a stuck memory; the transaction stays open.
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_MAX - WAIT_W'(1)) begin
              timeout_o <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
